// File: rtl/phase_advance_ctrl_pkg.sv
// Shared definitions for the phase advance controller: state encoding,
// default parameters and the phase-vector sanity helper.
package phase_advance_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_MEM = 2'd2,
    ST_HALT     = 2'd3
  } ctrl_state_t;

  localparam int MEM_TIMEOUT_DEFAULT = 16;
  localparam int STALL_W_DEFAULT     = 16;

  // True when exactly one phase line is active.
  function automatic logic is_one_hot5(input logic [4:0] v);
    return ($countones(v) == 1);
  endfunction

endpackage

// File: rtl/phase_advance_ctrl_exec_edge_detect.sv
// Rising-edge detector for the exec start/resume request.
// A level held high produces a single one-cycle pulse.
module exec_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic exec,
  output logic rise
);

  logic exec_q;

  // One-cycle history of exec, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) exec_q <= 1'b0;
    else       exec_q <= exec;
  end

  assign rise = exec & ~exec_q;

endmodule

// File: rtl/phase_advance_ctrl.sv
// Phase advance controller: gates the phase counter, issues memory
// requests in p1 (fetch) and p4 (data), handles HLT, memory timeout
// and malformed phase vectors.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | out of reset, waiting for first exec rising edge
// RUN      | phases advancing; zero-wait memory completes in place
// WAIT_MEM | memory request outstanding, phase counter frozen
// HALT     | stopped by HLT, bus timeout or phase fault; exec resumes
module phase_advance_ctrl
  import phase_advance_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int STALL_W     = STALL_W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               p1,
  input  logic               p2,
  input  logic               p3,
  input  logic               p4,
  input  logic               p5,
  input  logic               exec,
  input  logic               dataAccess,
  input  logic               haltInstr,
  input  logic               memReady,
  output logic               changeEnable,
  output logic               memReq,
  output logic               memIsData,
  output logic               halted,
  output logic               busError,
  output logic               phaseError,
  output logic [STALL_W-1:0] stallCount
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  // Loaded on entry to WAIT_MEM; terminal count 0 marks the last allowed cycle.
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_t        state, next_state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [STALL_W-1:0] stall;
  logic               bus_err, phase_err;
  logic               resumed;
  logic               exec_rise;
  logic               phase_ok, need_mem;
  logic               set_bus_err, set_phase_err, load_wait;

  exec_edge_detect u_exec_edge (
    .clock (clock),
    .reset (reset),
    .exec  (exec),
    .rise  (exec_rise)
  );

  assign phase_ok  = is_one_hot5({p5, p4, p3, p2, p1});
  assign need_mem  = p1 | (p4 & dataAccess);
  assign memIsData = p4;
  assign halted    = (state == ST_IDLE) || (state == ST_HALT);

  // Next-state and output decode; phase fault outranks every other event.
  always_comb begin
    next_state    = state;
    changeEnable  = 1'b0;
    memReq        = 1'b0;
    set_bus_err   = 1'b0;
    set_phase_err = 1'b0;
    load_wait     = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (exec_rise) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (!phase_ok) begin
          set_phase_err = 1'b1;
          next_state    = ST_HALT;
        end else if (need_mem) begin
          memReq = 1'b1;
          if (memReady) begin
            changeEnable = 1'b1;
          end else begin
            load_wait  = 1'b1;
            next_state = ST_WAIT_MEM;
          end
        end else if (p5 && haltInstr && !resumed) begin
          next_state = ST_HALT;
        end else begin
          changeEnable = 1'b1;
        end
      end
      ST_WAIT_MEM: begin
        memReq = 1'b1;
        if (!phase_ok) begin
          set_phase_err = 1'b1;
          next_state    = ST_HALT;
        end else if (memReady) begin
          changeEnable = 1'b1;
          next_state   = ST_RUN;
        end else if (wait_cnt == '0) begin
          set_bus_err = 1'b1;
          next_state  = ST_HALT;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State, timeout down-counter, stall counter and sticky fault flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      stall     <= '0;
      bus_err   <= 1'b0;
      phase_err <= 1'b0;
      resumed   <= 1'b0;
    end else begin
      state   <= next_state;
      resumed <= (state == ST_HALT) && (next_state == ST_RUN);
      if (load_wait)
        wait_cnt <= WAIT_LOAD;
      else if (state == ST_WAIT_MEM && wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;
      if (state == ST_WAIT_MEM && stall != {STALL_W{1'b1}})
        stall <= stall + 1'b1;
      if (set_bus_err)   bus_err   <= 1'b1;
      if (set_phase_err) phase_err <= 1'b1;
    end
  end

  assign busError   = bus_err;
  assign phaseError = phase_err;
  assign stallCount = stall;

endmodule

// File: tb/tb_phase_advance_ctrl.sv
// Directed bench for phase_advance_ctrl with a rule-level reference model
// checked every cycle, plus hand-computed literal checks per scenario.
module tb_phase_advance_ctrl;

  localparam int MEM_TIMEOUT = 16;
  localparam int STALL_W     = 16;
  localparam int MD_IDLE = 0, MD_RUN = 1, MD_WAIT = 2, MD_HALT = 3;

  logic clock = 1'b0;
  logic reset, p1, p2, p3, p4, p5, exec, dataAccess, haltInstr, memReady;
  logic changeEnable, memReq, memIsData, halted, busError, phaseError;
  logic [STALL_W-1:0] stallCount;

  int n_checks = 0;
  int n_fail   = 0;

  int         phase_idx;
  bit         force_en;
  logic [4:0] force_val;

  int m_mode, m_waited, m_stall, m_idx;
  bit m_bus, m_perr, m_exec_prev, m_fresh, started;

  typedef struct {
    bit ce;
    bit req;
    bit halted;
    bit set_bus;
    bit set_perr;
    int nxt;
  } pred_t;

  phase_advance_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .STALL_W(STALL_W)) dut (
    .clock(clock), .reset(reset),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5),
    .exec(exec), .dataAccess(dataAccess), .haltInstr(haltInstr), .memReady(memReady),
    .changeEnable(changeEnable), .memReq(memReq), .memIsData(memIsData),
    .halted(halted), .busError(busError), .phaseError(phaseError),
    .stallCount(stallCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // What the controller must do this cycle, from the behavioural rules.
  function automatic pred_t predict();
    pred_t      r;
    logic [4:0] ph;
    bit         busy, rise;
    r.ce = 0; r.req = 0; r.set_bus = 0; r.set_perr = 0; r.nxt = m_mode;
    ph   = {p5, p4, p3, p2, p1};
    rise = exec && !m_exec_prev;
    busy = (m_mode == MD_RUN) || (m_mode == MD_WAIT);
    r.halted = !busy;
    if (!busy) begin
      if (rise) r.nxt = MD_RUN;
    end else if ($countones(ph) != 1) begin
      r.set_perr = 1;
      r.nxt      = MD_HALT;
      r.req      = (m_mode == MD_WAIT);
    end else if (m_mode == MD_WAIT) begin
      r.req = 1;
      if (memReady) begin
        r.ce = 1; r.nxt = MD_RUN;
      end else if (m_waited + 1 >= MEM_TIMEOUT) begin
        r.set_bus = 1; r.nxt = MD_HALT;
      end
    end else begin
      if (ph[0] || (ph[3] && dataAccess)) begin
        r.req = 1;
        r.ce  = memReady;
        if (!memReady) r.nxt = MD_WAIT;
      end else if (ph[4] && haltInstr && !m_fresh) begin
        r.nxt = MD_HALT;
      end else begin
        r.ce = 1;
      end
    end
    return r;
  endfunction

  // Model state update, including the external phase counter position.
  always @(posedge clock) begin
    pred_t p;
    p = predict();
    if (reset) begin
      started = 1; m_mode = MD_IDLE; m_waited = 0; m_stall = 0;
      m_bus = 0; m_perr = 0; m_fresh = 0; m_idx = 0; m_exec_prev = 0;
    end else begin
      if (m_mode == MD_WAIT && m_stall < (1 << STALL_W) - 1) m_stall++;
      m_waited    = (m_mode == MD_WAIT && p.nxt == MD_WAIT) ? m_waited + 1 : 0;
      m_fresh     = (m_mode == MD_HALT && p.nxt == MD_RUN);
      m_bus       = m_bus | p.set_bus;
      m_perr      = m_perr | p.set_perr;
      if (p.ce) m_idx = (m_idx + 1) % 5;
      m_exec_prev = exec;
      m_mode      = p.nxt;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    pred_t p;
    if (started) begin
      p = predict();
      chk("model_changeEnable", changeEnable, p.ce);
      chk("model_memReq", memReq, p.req);
      chk("model_memIsData", memIsData, p4);
      chk("model_halted", halted, p.halted);
      chk("model_busError", busError, m_bus);
      chk("model_phaseError", phaseError, m_perr);
      chk("model_stallCount", stallCount, m_stall);
    end
  end

  task automatic apply_phase();
    logic [4:0] v;
    v = force_en ? force_val : (5'b00001 << phase_idx);
    {p5, p4, p3, p2, p1} = v;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    phase_idx = m_idx;
    apply_phase();
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic wait_phase(input int idx);
    for (int n = 0; n < 20 && phase_idx != idx; n++) tick();
    if (phase_idx != idx) begin
      n_fail++;
      $display("FAIL wait_phase: got phase %0d expected %0d", phase_idx, idx);
    end
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1; exec = 0; dataAccess = 0; haltInstr = 0; memReady = 0;
    force_en = 0; force_val = 5'b0; phase_idx = 0;
    apply_phase();
    repeat (3) tick();
    reset = 0;
    settle();
    chk("reset_halted", halted, 1);
    chk("reset_ce", changeEnable, 0);
    chk("reset_req", memReq, 0);
    chk("reset_stall", stallCount, 0);

    // Free run with zero-wait memory.
    exec = 1; memReady = 1;
    tick(); exec = 0; settle();
    chk("run_p1_ce", changeEnable, 1);
    chk("run_p1_req", memReq, 1);
    chk("run_p1_isdata", memIsData, 0);
    for (int i = 0; i < 12; i++) begin
      tick(); settle();
      chk("run_ce", changeEnable, 1);
    end
    chk("run_stall", stallCount, 0);

    // Fetch with memReady three cycles late.
    wait_phase(0);
    memReady = 0; settle();
    chk("fetch_req", memReq, 1);
    chk("fetch_isdata", memIsData, 0);
    chk("fetch_ce", changeEnable, 0);
    tick(); settle(); chk("fetch_w1_ce", changeEnable, 0);
    tick(); settle(); chk("fetch_w2_ce", changeEnable, 0);
    tick(); memReady = 1; settle();
    chk("fetch_w3_ce", changeEnable, 1);
    chk("fetch_w3_req", memReq, 1);
    tick(); settle();
    chk("fetch_stall", stallCount, 3);
    chk("fetch_p2_req", memReq, 0);

    // Data access that never completes.
    dataAccess = 1;
    wait_phase(3);
    memReady = 0; settle();
    chk("data_req", memReq, 1);
    chk("data_isdata", memIsData, 1);
    chk("data_ce", changeEnable, 0);
    tick();
    repeat (15) tick();
    settle();
    chk("to_w16_bus", busError, 0);
    chk("to_w16_req", memReq, 1);
    tick(); settle();
    chk("to_bus", busError, 1);
    chk("to_halted", halted, 1);
    chk("to_ce", changeEnable, 0);
    chk("to_req", memReq, 0);
    chk("to_stall", stallCount, 19);

    // Resume with flag set; memReady lands on the timeout cycle.
    exec = 1;
    tick(); exec = 0; settle();
    chk("res_halted", halted, 0);
    chk("res_req", memReq, 1);
    tick();
    repeat (15) tick();
    memReady = 1; settle();
    chk("tie_ce", changeEnable, 1);
    tick(); settle();
    chk("tie_halted", halted, 0);
    chk("tie_stall", stallCount, 35);
    chk("tie_bus_sticky", busError, 1);

    // HLT in p5, resume with haltInstr still high, exec level held.
    dataAccess = 0;
    wait_phase(4);
    haltInstr = 1; settle();
    chk("hlt_ce", changeEnable, 0);
    tick(); settle();
    chk("hlt_halted", halted, 1);
    exec = 1;
    tick(); settle();
    chk("hlt_resume_ce", changeEnable, 1);
    chk("hlt_resume_halted", halted, 0);
    tick(); settle();
    chk("hlt_p1_halted", halted, 0);
    wait_phase(4);
    settle();
    chk("hlt2_ce", changeEnable, 0);
    tick();
    repeat (3) tick();
    settle();
    chk("hlt_level_held", halted, 1);
    exec = 0;
    tick(); exec = 1;
    tick(); exec = 0; haltInstr = 0; settle();
    chk("hlt_resume2", halted, 0);

    // Two phases active at once.
    tick();
    force_en = 1; force_val = 5'b00110; apply_phase(); settle();
    chk("perr_ce", changeEnable, 0);
    chk("perr_pre", phaseError, 0);
    tick(); settle();
    chk("perr_flag", phaseError, 1);
    chk("perr_halted", halted, 1);
    force_en = 0; apply_phase(); exec = 1;
    tick(); exec = 0; settle();
    chk("perr_resume", halted, 0);
    chk("perr_sticky", phaseError, 1);

    // Reset in WAIT_MEM alongside memReady and exec.
    memReady = 1;
    wait_phase(0);
    memReady = 0;
    tick(); tick();
    reset = 1; memReady = 1; exec = 1; settle();
    chk("rst_pre_req", memReq, 1);
    tick(); settle();
    chk("rst_req", memReq, 0);
    chk("rst_halted", halted, 1);
    chk("rst_bus", busError, 0);
    chk("rst_perr", phaseError, 0);
    chk("rst_stall", stallCount, 0);
    reset = 0; exec = 0;
    tick(); settle();
    chk("rst_idle", halted, 1);
    chk("rst_idle_ce", changeEnable, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
